// File: rtl/count_sequencer_if.sv
// count_sequencer_if: control and counter-side signals of count_sequencer.
// master = system/counter side, slave = the sequencer itself.
interface count_sequencer_if #(
  parameter int WIDTH = 3,
  parameter int PW    = 8
);
  logic             Start;
  logic             Stop;
  logic             Mode;
  logic [WIDTH-1:0] Limit;
  logic [WIDTH-1:0] Count;
  logic             Carry2;
  logic             En;
  logic             CntRst;
  logic             Tick;
  logic             Busy;
  logic             Done;
  logic [PW-1:0]    Periods;
  logic             Err;

  modport master (
    output Start, Stop, Mode, Limit,
    output Count, Carry2,
    input  En, CntRst, Tick, Busy,
    input  Done, Periods, Err
  );

  modport slave (
    input  Start, Stop, Mode, Limit,
    input  Count, Carry2,
    output En, CntRst, Tick, Busy,
    output Done, Periods, Err
  );
endinterface

// File: rtl/count_sequencer.sv
// count_sequencer: one-hot FSM sequencing a WIDTH-bit up-counter.
// Define SEQ_OVF_CHECK_EN for the sticky counter-overflow fault (Err).
module count_sequencer #(
  parameter int WIDTH = 3,
  parameter int PW    = 8
) (
  input logic              Clk,
  input logic              Rst,
  count_sequencer_if.slave bus
);

  localparam int I_IDLE  = 0;
  localparam int I_CLEAR = 1;
  localparam int I_RUN   = 2;
  localparam int I_DONE  = 3;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_CLEAR = 4'b0010,
    S_RUN   = 4'b0100,
    S_DONE  = 4'b1000
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] lim_q;
  logic             mode_q;
  logic [PW-1:0]    per_q;
  logic             cntrst_q;
  logic             busy_q;
  logic             done_q;
  logic             latch;
  logic             run;
  logic             at_lim;
  logic             ovf;

  assign run    = state_q[I_RUN];
  assign at_lim = (bus.Count == lim_q);

`ifdef SEQ_OVF_CHECK_EN
  logic err_q;

  assign ovf = run && (bus.Count > lim_q);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      err_q <= 1'b0;
    end else if (run && (bus.Carry2 || ovf)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.Err = err_q;
`else
  logic unused_carry;

  assign unused_carry = bus.Carry2;
  assign ovf          = 1'b0;
  assign bus.Err      = 1'b0;
`endif

  // Stop wins over a coincident terminal count.
  assign bus.Tick = run & at_lim & ~bus.Stop;
  assign bus.En   = run & ~at_lim;

  always_comb begin
    state_d = state_q;
    latch   = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (bus.Start && !bus.Stop) begin
          state_d = S_CLEAR;
          latch   = 1'b1;
        end
      end
      state_q[I_CLEAR]: begin
        state_d = S_RUN;
      end
      state_q[I_RUN]: begin
        if (bus.Stop || ovf) begin
          state_d = S_IDLE;
        end else if (at_lim) begin
          state_d = mode_q ? S_CLEAR : S_DONE;
        end
      end
      state_q[I_DONE]: begin
        if (bus.Stop) begin
          state_d = S_IDLE;
        end else if (bus.Start) begin
          state_d = S_CLEAR;
          latch   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // CntRst feeds the counter's async clear, so it comes straight off a flop.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      cntrst_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      lim_q    <= '0;
      mode_q   <= 1'b0;
      per_q    <= '0;
    end else begin
      state_q  <= state_d;
      cntrst_q <= state_d[I_IDLE] | state_d[I_CLEAR];
      busy_q   <= state_d[I_CLEAR] | state_d[I_RUN];
      done_q   <= state_d[I_DONE];
      if (latch) begin
        lim_q  <= bus.Limit;
        mode_q <= bus.Mode;
        per_q  <= '0;
      end else if (bus.Tick && (per_q != '1)) begin
        per_q  <= per_q + 1'b1;
      end
    end
  end

  assign bus.CntRst  = cntrst_q;
  assign bus.Busy    = busy_q;
  assign bus.Done    = done_q;
  assign bus.Periods = per_q;

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
- Control FSM that sequences a WIDTH-bit up-counter datapath: three half-adder incrementer plus count register, with En, Carry2 and active-high async Rst.
- Drives the counter's En and clear, watches its Count and Carry2, and produces a terminal-count Tick at a programmable limit.
- Runs in one-shot or continuous (periodic) mode and keeps a saturating count of completed periods.
- Sits between the system control logic and the counter instance in the lab top level.

Parameters:
- WIDTH, 3, width of the counter datapath, Count and Limit
- PW, 8, width of the Periods output

Ports:
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-low reset
- Start  input  1  level, sampled on Clk; begins a run from IDLE or DONE
- Stop  input  1  level, sampled on Clk; aborts to IDLE
- Mode  input  1  0 = one-shot, 1 = continuous; sampled with Start
- Limit  input  WIDTH  terminal count; sampled with Start
- Count  input  WIDTH  current value from the counter
- Carry2  input  1  carry out from the counter's top half adder
- En  output  1  counter enable
- CntRst  output  1  counter clear, active-high, drives the counter's Rst
- Tick  output  1  one-cycle pulse, Count reached limit
- Busy  output  1  high in CLEAR or RUN
- Done  output  1  high in DONE
- Periods  output  PW  completed periods since last start, saturating
- Err  output  1  sticky overflow fault (only with feature; else tied 0)

Behaviour:
- One clock (Clk); reset is asynchronous and active-low (Rst). Rst low forces the following immediately:
  - state = IDLE
  - CntRst = 1
  - En, Tick, Busy, Done = 0
  - Periods = 0, Err = 0
  - latched limit and mode = 0
- State register is one-hot. CntRst is taken directly from a state flop (glitch-free), because it drives an async clear.
- States:
  - IDLE: CntRst = 1. Start -> CLEAR; latch Limit and Mode; Periods <= 0.
  - CLEAR: CntRst = 1, Busy = 1. Unconditional -> RUN (1 cycle).
  - RUN: Busy = 1, En = (Count != lim), Tick = (Count == lim), both combinational from state, Count and lim.
    - On Tick: Periods <= Periods + 1, saturating at 2^PW-1.
    - Mode latched 1 -> CLEAR; otherwise -> DONE.
    - Stop has priority over Tick: Stop in RUN -> IDLE, with no Tick and no Periods increment.
  - DONE: Done = 1, En = 0, CntRst = 0, so the counter holds lim. Start -> CLEAR (relatch, Periods <= 0). Stop -> IDLE. Start and Stop together -> IDLE.
- Start in CLEAR or RUN is ignored. Limit and Mode changes after latch have no effect until the next Start.
- Timing, Start sampled at edge 0:
  - CLEAR during cycle 1.
  - Count = 0 in cycle 2; Tick in cycle lim+2.
  - Continuous period = lim+2 cycles (lim+1 counting cycles, 1 clear cycle).
- lim = 0: Tick on the first RUN cycle, and En never asserts.
- lim = 2^WIDTH-1: the counter holds at all-ones with En = 0, so Carry2 never asserts in correct operation. No wrap past the limit is ever allowed.
- Reset mid-run: immediate return to IDLE, with the counter cleared via CntRst = 1.

Optional Feature:
- Macro SEQ_OVF_CHECK_EN.
- Defined:
  - Carry2 = 1 while in RUN sets Err (sticky), clearable only by Rst.
  - Count > lim in RUN also sets Err and forces -> IDLE.
- Undefined:
  - Carry2 is ignored and Err is tied 0.
  - Count > lim is not checked; the FSM waits for equality.

Test Plan:
- Reset: hold Rst = 0 mid-RUN -> immediately state IDLE, CntRst = 1, En = 0, Periods = 0, Err = 0; release and stay IDLE with Start = 0.
- One-shot, Limit = 3, Mode = 0, Start pulse at edge 0 -> CLEAR in cycle 1; Count 0,1,2,3 in cycles 2-5; Tick only in cycle 5; Done = 1 from cycle 6; Count holds 3; Periods = 1.
- Continuous, Limit = 2, Mode = 1 -> Tick every 4 cycles; after 300 periods Periods = 255 (saturated); changing Limit to 5 mid-run leaves the period unchanged.
- Limit = 0 continuous -> En never high, Tick every 2 cycles. Limit = 7 one-shot -> Count reaches 7, Carry2 never high, Done set, Err = 0.
- Stop in RUN at Count == lim (simultaneous) -> IDLE, no Tick, Periods unchanged, Count cleared. Start + Stop together in DONE -> IDLE.
- With SEQ_OVF_CHECK_EN: force Carry2 = 1 for one cycle in RUN -> Err = 1 and stays 1 through later runs until Rst. Without the macro, the same stimulus -> Err = 0.
